// File: rtl/fetch_sequencer.sv
// Fetch sequencer: control FSM for the PC / instruction-fetch stage.
// Drives PC init/halt/branch controls, handshakes with variable-latency
// instruction memory, honours decode stalls and program halt, and stops a
// run through a cycle watchdog.
module fetch_sequencer #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             imem_ready,
    input  logic             branch_taken,
    input  logic             stall_req,
    input  logic             prog_done,
    output logic             pc_init,
    output logic             pc_halt,
    output logic             pc_branch_en,
    output logic             imem_req,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cyc_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_t;

    // Cycle count value at which the watchdog forces the run to stop.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nx;

    logic retire;
    logic cyc_tick;
    logic cnt_clr;
    logic wd_fire;
    logic wd_hit;

    assign wd_hit = (cyc_count == WD_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and output decode; watchdog outranks every EXEC/FETCH input.
    always_comb begin
        state_nx     = state;
        pc_init      = 1'b0;
        pc_halt      = 1'b1;
        pc_branch_en = 1'b0;
        imem_req     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        retire       = 1'b0;
        cyc_tick     = 1'b0;
        cnt_clr      = 1'b0;
        wd_fire      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_INIT;
                end
            end
            S_INIT: begin
                pc_init  = 1'b1;
                pc_halt  = 1'b0;
                busy     = 1'b1;
                cnt_clr  = 1'b1;
                state_nx = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                cyc_tick = 1'b1;
                if (wd_hit) begin
                    wd_fire  = 1'b1;
                    state_nx = S_DONE;
                end else if (imem_ready) begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                busy     = 1'b1;
                cyc_tick = 1'b1;
                if (wd_hit) begin
                    wd_fire  = 1'b1;
                    state_nx = S_DONE;
                end else if (prog_done) begin
                    retire   = 1'b1;
                    state_nx = S_DONE;
                end else if (!stall_req) begin
                    pc_halt      = 1'b0;
                    pc_branch_en = branch_taken;
                    retire       = 1'b1;
                    state_nx     = S_FETCH;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx = S_INIT;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Saturating run counters and sticky watchdog flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
            cyc_count   <= '0;
            timeout     <= 1'b0;
        end else if (cnt_clr) begin
            instr_count <= '0;
            cyc_count   <= '0;
            timeout     <= 1'b0;
        end else begin
            if (retire && (instr_count != CNT_MAX)) begin
                instr_count <= instr_count + 1'b1;
            end
            if (cyc_tick && (cyc_count != CNT_MAX)) begin
                cyc_count <= cyc_count + 1'b1;
            end
            if (wd_fire) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control FSM that sequences the program counter / instruction-fetch stage. It drives the PC's init, halt and branch-enable controls, and handshakes with instruction memory, which has variable latency. It also handles pipeline stall requests, program completion and a cycle watchdog. It sits between the top-level start/done interface and the PC register.

Parameters:
CNT_W, 16, width of the retired-instruction and cycle counters
MAX_CYCLES, 16'hFFFF, watchdog limit: total cycles from end of INIT before forced stop

Ports:
clk  input  1  system clock; all state changes on posedge
rst_n  input  1  asynchronous, active-low reset
start  input  1  pulse: begin a program run; honoured only in IDLE and DONE
imem_ready  input  1  instruction memory data valid for the outstanding request
branch_taken  input  1  decoded relative branch with ALU zero flag set, valid in EXEC
stall_req  input  1  hazard stall from decode; freezes PC in EXEC
prog_done  input  1  decoded halt instruction, valid in EXEC
pc_init  output  1  PC clear to 0
pc_halt  output  1  PC freeze
pc_branch_en  output  1  PC loads PC+Target this cycle
imem_req  output  1  instruction memory request
busy  output  1  program running (INIT, FETCH, EXEC)
done  output  1  program finished (DONE state)
timeout  output  1  sticky: last run ended by the watchdog
instr_count  output  CNT_W  instructions retired in the current/last run
cyc_count  output  CNT_W  cycles elapsed since INIT in the current/last run

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counters=0; timeout=0.
  - pc_halt=1; all other outputs 0.
- States: IDLE, INIT, FETCH, EXEC, DONE. Outputs are decoded from state and inputs as listed per state; no extra pipeline delay.
- IDLE:
  - Outputs: pc_halt=1.
  - start=1 -> INIT.
- INIT (exactly 1 cycle):
  - Outputs: pc_init=1, pc_halt=0.
  - Clears instr_count, cyc_count and timeout.
  - Always -> FETCH.
- FETCH:
  - Outputs: imem_req=1, pc_halt=1.
  - imem_ready=1 -> EXEC; else stay in FETCH.
  - imem_ready is ignored in every other state.
- EXEC:
  - prog_done=1 (highest priority):
    - pc_halt=1, pc_branch_en=0; instr_count+1 (the halt instruction retires).
    - -> DONE.
  - else stall_req=1:
    - pc_halt=1, pc_branch_en=0; stay in EXEC; no retire.
  - else:
    - pc_halt=0, pc_branch_en=branch_taken; instr_count+1.
    - -> FETCH.
- DONE:
  - Outputs: done=1, pc_halt=1. Counters and timeout hold their values.
  - start=1 -> INIT.
- Counting:
  - cyc_count increments every cycle in FETCH and EXEC.
  - Both counters saturate at all-ones; they never wrap.
- Watchdog:
  - In FETCH or EXEC, when cyc_count==MAX_CYCLES-1, next state is DONE with timeout=1.
  - The watchdog overrides prog_done, stall_req and imem_ready in that cycle. pc_halt=1 and no retire occurs in that cycle.
- busy=1 exactly in INIT, FETCH and EXEC.
- start in INIT, FETCH or EXEC is ignored (no restart mid-run).
- rst_n asserted mid-run: immediate return to IDLE. A late imem_ready after reset is ignored.

Test Plan:
1. Reset then start, imem_ready tied 1, prog_done on the 4th EXEC -> pc_init high 1 cycle; states alternate FETCH/EXEC; instr_count=4; cyc_count=8; done=1; timeout=0.
2. imem_ready delayed 3 cycles per fetch, 2 instructions then prog_done -> imem_req held 4 cycles per fetch; pc_halt=1 throughout FETCH; cyc_count=2*(4+1)+4+1=15; instr_count=3.
3. branch_taken=1 in EXEC of instruction 2 -> pc_branch_en=1 and pc_halt=0 for exactly that cycle; pc_branch_en=0 in every other cycle.
4. stall_req=1 for 2 cycles in EXEC with branch_taken=1 -> state stays EXEC; pc_halt=1 and pc_branch_en=0 during the stall; instr_count unchanged until stall_req drops.
5. MAX_CYCLES=10, prog_done never asserted -> DONE entered after cyc_count reaches 9; timeout=1; done=1. A new start clears timeout in INIT.
6. rst_n pulsed low mid-FETCH, then start pulsed in EXEC -> immediate IDLE with pc_halt=1 and counters 0; start during a run does not re-enter INIT.
